// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC owner and single-outstanding instruction fetch sequencer
module pc_add2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = a_i + b_i;
endmodule

module pc_fetch_ctrl #(
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0,
  parameter int                   INC       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redirect_valid_i,
  input  logic [DATAWIDTH-1:0] redirect_target_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  output logic                 if_valid_o,
  output logic [DATAWIDTH-1:0] if_pc_o,
  output logic [DATAWIDTH-1:0] if_instr_o,
  input  logic                 if_ready_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_e;
  state_e               state_q;
  logic                 drop_q;
  logic [DATAWIDTH-1:0] pc_q, pc_d, pc_inc, redir_pc, if_pc_q, if_instr_q;
  pc_add2 #(.W(DATAWIDTH)) u_add (
    .a_i(pc_q),
    .b_i(DATAWIDTH'(INC)),
    .y_o(pc_inc)
  );
  assign redir_pc    = {redirect_target_i[DATAWIDTH-1:2], 2'b00};
  assign imem_req_o  = state_q == REQ;
  assign imem_addr_o = pc_q;
  assign if_valid_o  = state_q == OUT;
  assign if_pc_o     = if_pc_q;
  assign if_instr_o  = if_instr_q;
  // redirect wins over sequential advance; IDLE ignores redirects
  always_comb begin
    pc_d = (redirect_valid_i && state_q != IDLE) ? redir_pc :
           (state_q == OUT && if_ready_i)        ? pc_inc   : pc_q;
  end
  // fetch FSM: a redirect racing an accepted request marks its response for dropping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: if (imem_gnt_i) begin
          state_q <= WAIT;
          drop_q  <= redirect_valid_i;
        end
        WAIT: if (imem_rvalid_i) begin
          drop_q <= 1'b0;
          if (drop_q || redirect_valid_i) state_q <= REQ;
          else begin
            state_q    <= OUT;
            if_pc_q    <= pc_q;
            if_instr_q <= imem_rdata_i;
          end
        end else if (redirect_valid_i) drop_q <= 1'b1;
        OUT: if (redirect_valid_i || if_ready_i) state_q <= REQ;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
